// File: rtl/pluto_pkg.sv
// Shared constants for the quadrature decoder: snapshot word layout,
// transition lookup tables and the step classification helper.
package pluto_pkg;

  localparam int QW_DEF    = 14;
  localparam int CNT_LSB   = 0;
  localparam int IDX_LSB   = QW_DEF;
  localparam int VALID_BIT = 2 * QW_DEF;

  // Bit n set when {prev_ab, cur_ab} == n is a forward step (00->10->11->01->00)
  localparam logic [15:0] FWD_STEP = 16'h2814;
  // Bit n set when {prev_ab, cur_ab} == n is a reverse step
  localparam logic [15:0] REV_STEP = 16'h4182;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  function automatic step_e decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [3:0] code;
    code = {prev_ab, cur_ab};
    if (FWD_STEP[code])
      decode_step = STEP_FWD;
    else if (REV_STEP[code])
      decode_step = STEP_REV;
    else if ((prev_ab ^ cur_ab) == 2'b11)
      decode_step = STEP_ERR;
    else
      decode_step = STEP_HOLD;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchronizer followed by a stability filter: the output follows
// the synchronized pin only after it has disagreed for FILT_LEN clocks in a row.
module quad_input_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam logic [3:0] RUN_LAST = 4'(FILT_LEN - 1);

  logic       sync_1;
  logic       sync_2;
  logic [3:0] run_cnt;

  // Bring the asynchronous pin into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= din;
      sync_2 <= sync_1;
    end
  end

  // Count consecutive disagreements; any agreement restarts the run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout    <= 1'b0;
      run_cnt <= 4'd0;
    end else if (sync_2 != dout) begin
      if (run_cnt == RUN_LAST) begin
        dout    <= sync_2;
        run_cnt <= 4'd0;
      end else begin
        run_cnt <= run_cnt + 4'd1;
      end
    end else begin
      run_cnt <= 4'd0;
    end
  end

endmodule

// File: rtl/quad_counter_idx.sv
// Per-axis quadrature decoder: filtered A/B drive a wrapping 4x up/down count,
// Z rising edges latch the count, and snap captures a coherent status word.
module quad_counter_idx
  import pluto_pkg::*;
#(
  parameter int QW       = pluto_pkg::QW_DEF,
  parameter int FILT_LEN = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            quadA,
  input  logic            quadB,
  input  logic            quadZ,
  input  logic            zpol,
  input  logic            idx_arm,
  input  logic            snap,
  output logic [2*QW:0]   quad_out,
  output logic            quad_err,
  output logic [QW-1:0]   count_live
);

  logic          a_f;
  logic          b_f;
  logic          z_f;
  logic          z_eff;
  logic [1:0]    prev_ab;
  logic          prev_z;
  logic [QW-1:0] count;
  logic [QW-1:0] count_nxt;
  logic [QW-1:0] idx_count;
  logic          idx_valid;
  logic          err;
  logic          idx_evt;
  step_e         step;

  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (.clk(clk), .reset(reset), .din(quadA), .dout(a_f));
  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (.clk(clk), .reset(reset), .din(quadB), .dout(b_f));
  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (.clk(clk), .reset(reset), .din(quadZ), .dout(z_f));

  assign z_eff   = z_f ^ zpol;
  assign idx_evt = idx_arm & z_eff & ~prev_z;

  // Classify the A/B transition and compute the next count (modulo 2^QW)
  always_comb begin
    step      = decode_step(prev_ab, {a_f, b_f});
    count_nxt = count;
    case (step)
      STEP_FWD: count_nxt = count + QW'(1);
      STEP_REV: count_nxt = count - QW'(1);
      default:  count_nxt = count;
    endcase
  end

  // Position count and previous-sample history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      prev_ab <= 2'b00;
      prev_z  <= 1'b0;
    end else begin
      count   <= count_nxt;
      prev_ab <= {a_f, b_f};
      prev_z  <= z_eff;
    end
  end

  // Index latch; a new event wins over the snap clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_count <= '0;
      idx_valid <= 1'b0;
    end else if (idx_evt) begin
      idx_count <= count_nxt;
      idx_valid <= 1'b1;
    end else if (snap) begin
      idx_valid <= 1'b0;
    end
  end

  // Sticky illegal-transition flag; a new error wins over the snap clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err <= 1'b0;
    else if (step == STEP_ERR)
      err <= 1'b1;
    else if (snap)
      err <= 1'b0;
  end

  // Snapshot uses register values from before the snap edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quad_out <= '0;
      quad_err <= 1'b0;
    end else if (snap) begin
      quad_out <= {idx_valid, idx_count, count};
      quad_err <= err;
    end
  end

  assign count_live = count;

endmodule

// File: tb/tb_quad_counter_idx.sv
module tb_quad_counter_idx;

  localparam int QW   = 14;
  localparam int FL   = 4;
  localparam int OW   = 2 * QW + 1;
  localparam int MASK = (1 << QW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          quadA;
  logic          quadB;
  logic          quadZ;
  logic          zpol;
  logic          idx_arm;
  logic          snap;
  logic [OW-1:0] quad_out;
  logic          quad_err;
  logic [QW-1:0] count_live;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         m_count;
  int         m_idx;
  bit         m_valid;
  bit         m_err;
  bit         m_z;
  logic [1:0] m_pos;
  logic [1:0] gray_seq [4];

  always #5 clk = ~clk;

  quad_counter_idx #(.QW(QW), .FILT_LEN(FL)) dut (
    .clk(clk), .reset(reset), .quadA(quadA), .quadB(quadB), .quadZ(quadZ),
    .zpol(zpol), .idx_arm(idx_arm), .snap(snap),
    .quad_out(quad_out), .quad_err(quad_err), .count_live(count_live)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] exp_word();
    logic [31:0] w;
    w = 32'(m_count & MASK) | (32'(m_idx & MASK) << QW);
    if (m_valid) w[2*QW] = 1'b1;
    return w;
  endfunction

  task automatic apply_ab();
    logic [1:0] ab;
    ab    = gray_seq[m_pos];
    quadA = ab[1];
    quadB = ab[0];
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    quadA   = 1'($urandom_range(0, 1));
    quadB   = 1'($urandom_range(0, 1));
    quadZ   = 1'($urandom_range(0, 1));
    cyc(3);
    quadA   = 1'b0;
    quadB   = 1'b0;
    quadZ   = 1'b0;
    zpol    = 1'b0;
    idx_arm = 1'b0;
    snap    = 1'b0;
    cyc(2);
    reset   = 1'b0;
    m_count = 0;
    m_idx   = 0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_z     = 1'b0;
    m_pos   = 2'd0;
  endtask

  task automatic step(input int dir, input int hold);
    if (dir > 0) begin
      m_pos   = m_pos + 2'd1;
      m_count = (m_count + 1) & MASK;
    end else begin
      m_pos   = m_pos - 2'd1;
      m_count = (m_count + MASK) & MASK;
    end
    apply_ab();
    cyc(hold);
  endtask

  task automatic snap_check(input string tag);
    snap = 1'b1;
    cyc(1);
    snap = 1'b0;
    check({tag, "_word"}, 32'(quad_out), exp_word());
    check({tag, "_err"}, 32'(quad_err), 32'(m_err));
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  initial begin
    int hold;
    int r;
    int len;
    int pin;
    bit saw;

    gray_seq[0] = 2'b00;
    gray_seq[1] = 2'b10;
    gray_seq[2] = 2'b11;
    gray_seq[3] = 2'b01;
    reset = 1'b1; quadA = 1'b0; quadB = 1'b0; quadZ = 1'b0;
    zpol = 1'b0; idx_arm = 1'b0; snap = 1'b0;

    // reset values
    do_reset();
    cyc(1);
    check("rst_out", 32'(quad_out), 32'd0);
    check("rst_err", 32'(quad_err), 32'd0);
    check("rst_live", 32'(count_live), 32'd0);

    // forward count and pin-to-count latency
    m_pos = 2'd1;
    apply_ab();
    cyc(FL + 2);
    check("lat_before", 32'(count_live), 32'd0);
    cyc(1);
    check("lat_at", 32'(count_live), 32'd1);
    m_count = 1;
    cyc(3);
    for (int i = 0; i < 7; i++) step(1, 10);
    snap_check("fwd8");
    check("fwd8_cnt", 32'(quad_out[QW-1:0]), 32'd8);

    // reverse wrap
    do_reset();
    for (int i = 0; i < 3; i++) step(-1, 10);
    snap_check("rev3");
    check("rev3_cnt", 32'(quad_out[QW-1:0]), 32'h3FFD);

    // glitch rejection
    do_reset();
    quadA = 1'b1;
    cyc(FL - 1);
    quadA = 1'b0;
    cyc(12);
    check("glitch3", 32'(count_live), 32'd0);
    saw = 1'b0;
    quadA = 1'b1;
    for (int i = 0; i < FL; i++) begin
      cyc(1);
      if (count_live == 14'd1) saw = 1'b1;
    end
    quadA = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cyc(1);
      if (count_live == 14'd1) saw = 1'b1;
    end
    check("glitch4_seen", 32'(saw), 32'd1);
    check("glitch4_net", 32'(count_live), 32'd0);

    // index latch
    do_reset();
    idx_arm = 1'b1;
    cyc(2);
    for (int i = 0; i < 5; i++) step(1, 10);
    quadZ = 1'b1;
    m_idx = m_count;
    m_valid = 1'b1;
    cyc(10);
    snap_check("idx1");
    check("idx1_const", 32'(quad_out), 32'((1 << (2*QW)) | (5 << QW) | 5));
    snap_check("idx2");
    check("idx2_idx", 32'(quad_out[2*QW-1:QW]), 32'd5);
    quadZ = 1'b0;
    cyc(10);
    // Z edge landing on the same edge as snap
    quadZ = 1'b1;
    cyc(FL + 2);
    snap = 1'b1;
    cyc(1);
    snap = 1'b0;
    check("zsnap_cap", 32'(quad_out[2*QW]), 32'd0);
    m_idx = m_count;
    m_valid = 1'b1;
    cyc(5);
    snap_check("zsnap_next");

    // illegal transition
    do_reset();
    m_pos = 2'd2;
    apply_ab();
    m_err = 1'b1;
    cyc(10);
    check("ill_live", 32'(count_live), 32'd0);
    snap_check("ill1");
    snap_check("ill2");

    // randomized traffic against the model
    do_reset();
    for (int b = 0; b < 6; b++) begin
      idx_arm = 1'($urandom_range(0, 1));
      cyc(2);
      for (int s = 0; s < 20; s++) begin
        r    = $urandom_range(0, 99);
        hold = $urandom_range(8, 12);
        if (r < 35) begin
          step(1, hold);
        end else if (r < 70) begin
          step(-1, hold);
        end else if (r < 76) begin
          m_pos = m_pos + 2'd2;
          m_err = 1'b1;
          apply_ab();
          cyc(hold);
        end else if (r < 88) begin
          m_z   = !m_z;
          quadZ = m_z;
          if (m_z && idx_arm) begin
            m_idx   = m_count;
            m_valid = 1'b1;
          end
          cyc(hold);
        end else begin
          pin = $urandom_range(0, 2);
          len = $urandom_range(1, FL - 1);
          if (pin == 0) quadA = ~quadA;
          else if (pin == 1) quadB = ~quadB;
          else quadZ = ~quadZ;
          cyc(len);
          apply_ab();
          quadZ = m_z;
          cyc(hold);
        end
      end
      check("rnd_live", 32'(count_live), 32'(m_count));
      snap_check("rnd");
    end

    // asynchronous reset in mid-operation
    step(1, 10);
    step(1, 10);
    snap = 1'b1;
    cyc(1);
    snap = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_live", 32'(count_live), 32'd0);
    check("arst_out", 32'(quad_out), 32'd0);
    check("arst_err", 32'(quad_err), 32'd0);
    cyc(2);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
